// File: rtl/spi_display_responder.sv
// spi_display_responder: SPI mode-0 target. All SPI pins are oversampled and edge-detected on clk.
// Rev 1.0
`default_nettype none

module spi_display_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_csb,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       data_commandb,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  output logic       rx_abort,
  output logic       frame_active,
  output logic [7:0] frame_bytes
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] csb_sync_q, sclk_sync_q, mosi_sync_q, dc_sync_q;
  logic                   csb_dly_q, sclk_dly_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      csb_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      csb_dly_q   <= 1'b1;
      sclk_dly_q  <= 1'b0;
    end else begin
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], data_commandb};
      csb_dly_q   <= csb_sync_q[SYNC_STAGES-1];
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic csb_s, sclk_s, mosi_s, dc_s;
  logic csb_fall, csb_rise, sclk_rise, sclk_fall;

  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign csb_fall  = csb_dly_q & ~csb_s;
  assign csb_rise  = ~csb_dly_q & csb_s;
  assign sclk_rise = ~sclk_dly_q & sclk_s;
  assign sclk_fall = sclk_dly_q & ~sclk_s;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // Only seven bits are held; the eighth goes straight into rx_data.
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_dc_q, rx_dc_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_abort_q, rx_abort_d;
  logic [7:0] frame_bytes_q, frame_bytes_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_dc_d       = rx_dc_q;
    rx_valid_d    = 1'b0;
    rx_abort_d    = 1'b0;
    frame_bytes_d = frame_bytes_q;
    case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d       = ST_SHIFT;
          bit_cnt_d     = 3'd0;
          tx_shift_d    = tx_data;
          frame_bytes_d = 8'd0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_dc_d    = dc_s;
            rx_valid_d = 1'b1;
            if (frame_bytes_q != 8'hFF) begin
              frame_bytes_d = frame_bytes_q + 8'd1;
            end
          end
        end
        // A fall seen with the bit counter at 0 is the one after the 8th rise.
        if (sclk_fall) begin
          tx_shift_d = (bit_cnt_q == 3'd0) ? tx_data : {tx_shift_q[6:0], 1'b0};
        end
        if (csb_rise) begin
          state_d    = ST_IDLE;
          rx_abort_d = (bit_cnt_d != 3'd0);
          bit_cnt_d  = 3'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 8'd0;
      rx_data_q     <= 8'd0;
      rx_dc_q       <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_abort_q    <= 1'b0;
      frame_bytes_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_dc_q       <= rx_dc_d;
      rx_valid_q    <= rx_valid_d;
      rx_abort_q    <= rx_abort_d;
      frame_bytes_q <= frame_bytes_d;
    end
  end

  assign frame_active = (state_q == ST_SHIFT);
  assign spi_miso     = (state_q == ST_SHIFT) & tx_shift_q[7];
  assign rx_data      = rx_data_q;
  assign rx_dc        = rx_dc_q;
  assign rx_valid     = rx_valid_q;
  assign rx_abort     = rx_abort_q;
  assign frame_bytes  = frame_bytes_q;

endmodule

`default_nettype wire
